// File: rtl/mole_hit_scorer_if.sv
// Game-side bus for the whack-a-mole scorer: mole/button inputs and the
// registered score/miss/pulse outputs.
interface mole_hit_scorer_if;
  logic       mole_on;
  logic       whack;
  logic [1:0] level;
  logic       restart;
  logic [9:0] score;
  logic [1:0] misses;
  logic       hit_pulse;
  logic       miss_pulse;
  logic       mole_clear;
  logic       game_over;

  modport master (
    output mole_on, whack, level, restart,
    input  score, misses, hit_pulse, miss_pulse, mole_clear, game_over
  );

  modport slave (
    input  mole_on, whack, level, restart,
    output score, misses, hit_pulse, miss_pulse, mole_clear, game_over
  );
endinterface

// File: rtl/mole_hit_scorer.sv
// Whack-a-mole scorer: times the hit window for each mole, scores hits by
// difficulty, counts misses and ends the game at MAX_MISSES.
module mole_hit_scorer #(
  parameter int CLKS_PER_MS = 50000,
  parameter int MAX_SCORE   = 999,
  parameter int MAX_MISSES  = 3
) (
  input logic         clk,
  input logic         reset,
  mole_hit_scorer_if.slave bus
);
  localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_MS - 1);
  localparam logic [9:0]    SCORE_MAX = 10'(MAX_SCORE);
  localparam logic [1:0]    MISS_MAX  = 2'(MAX_MISSES);

  typedef enum logic [1:0] {WAIT, ARMED, COOL, OVER} state_t;

  state_t        state;
  logic [9:0]    score;
  logic [1:0]    misses;
  logic          hit_pulse, miss_pulse, mole_clear, game_over;
  logic [PW-1:0] presc;
  logic [9:0]    window;
  logic          mole_q;

  logic       rise, tick, expire, last_miss;
  logic [9:0] win_load, score_hit;
  logic [10:0] sum;
  logic [1:0] miss_inc;

  always_comb begin
    rise      = bus.mole_on & ~mole_q;
    tick      = (presc == PRESC_MAX);
    expire    = tick && (window == 10'd1);
    sum       = {1'b0, score} + {9'd0, bus.level} + 11'd1;
    score_hit = (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[9:0];
    miss_inc  = (misses == MISS_MAX) ? misses : misses + 2'd1;
    last_miss = (miss_inc == MISS_MAX);
    case (bus.level)
      2'd0:    win_load = 10'd1000;
      2'd1:    win_load = 10'd750;
      2'd2:    win_load = 10'd500;
      default: win_load = 10'd250;
    endcase
  end

  // mole_q resets/restarts high so a mole already showing is not a fresh rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= WAIT;
      score      <= '0;
      misses     <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      mole_clear <= 1'b0;
      game_over  <= 1'b0;
      presc      <= '0;
      window     <= '0;
      mole_q     <= 1'b1;
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      mole_clear <= 1'b0;
      mole_q     <= bus.mole_on;
      if (bus.restart) begin
        state     <= WAIT;
        score     <= '0;
        misses    <= '0;
        game_over <= 1'b0;
        presc     <= '0;
        window    <= '0;
        mole_q    <= 1'b1;
      end else begin
        case (state)
          WAIT: begin
            if (rise) begin
              state  <= ARMED;
              window <= win_load;
              presc  <= '0;
            end else if (bus.whack && !bus.mole_on) begin
              misses     <= miss_inc;
              miss_pulse <= 1'b1;
              if (last_miss) begin
                state     <= OVER;
                game_over <= 1'b1;
              end
            end
          end
          ARMED: begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) window <= window - 10'd1;
            // A whack wins over a same-cycle expiry or mole drop.
            if (bus.whack) begin
              score      <= score_hit;
              hit_pulse  <= 1'b1;
              mole_clear <= 1'b1;
              state      <= COOL;
            end else if (expire || !bus.mole_on) begin
              misses     <= miss_inc;
              miss_pulse <= 1'b1;
              mole_clear <= 1'b1;
              if (last_miss) begin
                state     <= OVER;
                game_over <= 1'b1;
              end else begin
                state <= COOL;
              end
            end
          end
          COOL: if (!bus.mole_on) state <= WAIT;
          OVER: game_over <= 1'b1;
          default: state <= WAIT;
        endcase
      end
    end
  end

  assign bus.score      = score;
  assign bus.misses     = misses;
  assign bus.hit_pulse  = hit_pulse;
  assign bus.miss_pulse = miss_pulse;
  assign bus.mole_clear = mole_clear;
  assign bus.game_over  = game_over;
endmodule

// File: tb/tb_mole_hit_scorer.sv
// Directed bench for mole_hit_scorer with a 2-cycle ms tick.
module tb_mole_hit_scorer;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  mole_hit_scorer_if bus ();

  mole_hit_scorer #(.CLKS_PER_MS(2), .MAX_SCORE(999), .MAX_MISSES(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_hit(input logic [1:0] lvl, output logic hp);
    bus.level   = lvl;
    bus.mole_on = 1'b1;
    tick();
    bus.whack = 1'b1;
    tick();
    bus.whack = 1'b0;
    hp = bus.hit_pulse;
    bus.mole_on = 1'b0;
    tick();
  endtask

  initial begin
    int   n;
    int   pulses;
    logic hp;
    reset       = 1'b1;
    bus.mole_on = 1'b0;
    bus.whack   = 1'b0;
    bus.level   = 2'd0;
    bus.restart = 1'b0;
    tick();
    tick();
    chk("rst_score", bus.score, 0);
    chk("rst_misses", bus.misses, 0);
    chk("rst_over", bus.game_over, 0);
    chk("rst_pulses", {bus.hit_pulse, bus.miss_pulse, bus.mole_clear}, 0);
    reset = 1'b0;
    tick();

    // Hit at level 2, whack 10 cycles after the rise.
    bus.level   = 2'd2;
    bus.mole_on = 1'b1;
    tick();
    repeat (9) tick();
    bus.whack = 1'b1;
    tick();
    bus.whack = 1'b0;
    chk("hit_pulse", bus.hit_pulse, 1);
    chk("hit_clear", bus.mole_clear, 1);
    chk("hit_nomiss", bus.miss_pulse, 0);
    chk("hit_score", bus.score, 3);
    chk("hit_misses", bus.misses, 0);
    tick();
    chk("hit_pulse_1cyc", {bus.hit_pulse, bus.mole_clear}, 0);
    bus.mole_on = 1'b0;
    tick();

    // Expiry at level 3: 250 ticks = 500 cycles.
    bus.level   = 2'd3;
    bus.mole_on = 1'b1;
    tick();
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.miss_pulse && n < 600);
    chk("exp_latency", n, 500);
    chk("exp_misses", bus.misses, 1);
    chk("exp_clear", bus.mole_clear, 1);
    chk("exp_nohit", bus.hit_pulse, 0);
    repeat (5) tick();
    bus.whack = 1'b1;
    tick();
    bus.whack = 1'b0;
    chk("cool_whack_hit", bus.hit_pulse, 0);
    chk("cool_whack_miss", bus.miss_pulse, 0);
    chk("cool_score", bus.score, 3);
    bus.mole_on = 1'b0;
    tick();
    tick();

    // Tie: whack on the expiry cycle at level 0 (1000 ticks = 2000 cycles).
    bus.level   = 2'd0;
    bus.mole_on = 1'b1;
    tick();
    repeat (1999) tick();
    chk("tie_pre_nomiss", bus.miss_pulse, 0);
    bus.whack = 1'b1;
    tick();
    bus.whack = 1'b0;
    chk("tie_hit", bus.hit_pulse, 1);
    chk("tie_nomiss", bus.miss_pulse, 0);
    chk("tie_score", bus.score, 4);
    chk("tie_misses", bus.misses, 1);
    bus.mole_on = 1'b0;
    tick();
    tick();

    // Mole drops before a whack.
    bus.level   = 2'd1;
    bus.mole_on = 1'b1;
    tick();
    repeat (3) tick();
    bus.mole_on = 1'b0;
    tick();
    chk("fall_miss", bus.miss_pulse, 1);
    chk("fall_clear", bus.mole_clear, 1);
    chk("fall_misses", bus.misses, 2);
    tick();

    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    chk("restart1_score", bus.score, 0);
    chk("restart1_misses", bus.misses, 0);

    // Three penalty whacks end the game.
    for (int i = 1; i <= 3; i++) begin
      bus.whack = 1'b1;
      tick();
      bus.whack = 1'b0;
      chk("pen_miss_pulse", bus.miss_pulse, 1);
      chk("pen_no_clear", bus.mole_clear, 0);
      chk("pen_misses", bus.misses, i);
    end
    chk("over_flag", bus.game_over, 1);
    bus.whack = 1'b1;
    tick();
    bus.whack = 1'b0;
    chk("over_whack_misses", bus.misses, 3);
    chk("over_whack_pulse", bus.miss_pulse, 0);
    bus.mole_on = 1'b1;
    tick();
    bus.whack = 1'b1;
    tick();
    bus.whack = 1'b0;
    chk("over_rise_score", bus.score, 0);
    chk("over_rise_hit", bus.hit_pulse, 0);
    chk("over_still", bus.game_over, 1);
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    chk("restart2_misses", bus.misses, 0);
    chk("restart2_over", bus.game_over, 0);
    chk("restart2_score", bus.score, 0);
    // Mole still high from before the restart: not a rise.
    bus.whack = 1'b1;
    tick();
    bus.whack = 1'b0;
    chk("stale_mole_hit", bus.hit_pulse, 0);
    chk("stale_mole_score", bus.score, 0);
    chk("stale_mole_misses", bus.misses, 0);
    bus.mole_on = 1'b0;
    tick();

    // Saturation: 249*4 + 2 = 998, then +4 -> 999, then hold.
    for (int i = 0; i < 249; i++) do_hit(2'd3, hp);
    do_hit(2'd1, hp);
    chk("sat_preset", bus.score, 998);
    do_hit(2'd3, hp);
    chk("sat_hit_pulse", hp, 1);
    chk("sat_clip", bus.score, 999);
    do_hit(2'd3, hp);
    chk("sat_hold_pulse", hp, 1);
    chk("sat_hold", bus.score, 999);

    // Async reset mid-window.
    bus.level   = 2'd0;
    bus.mole_on = 1'b1;
    tick();
    repeat (5) tick();
    #2 reset = 1'b1;
    #1;
    chk("areset_score", bus.score, 0);
    chk("areset_misses", bus.misses, 0);
    chk("areset_pulses", {bus.hit_pulse, bus.miss_pulse, bus.mole_clear, bus.game_over}, 0);
    tick();
    reset  = 1'b0;
    pulses = 0;
    repeat (10) begin
      tick();
      pulses += int'(bus.miss_pulse) + int'(bus.hit_pulse);
    end
    bus.mole_on = 1'b0;
    repeat (3) begin
      tick();
      pulses += int'(bus.miss_pulse) + int'(bus.hit_pulse);
    end
    chk("areset_no_pulse", pulses, 0);
    bus.whack = 1'b1;
    tick();
    bus.whack = 1'b0;
    chk("areset_resume", bus.misses, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
